fifo_rd_ctrl: RTL and testbench

//  Read-side pointer/flag controller of the async AXIS data FIFO.
//  - Consumes the write pointer after it crosses the NUM_STG synchroniser into the read domain.
//  - Drives the dual-port RAM read port and presents first-word-fall-through AXIS master output.
//  - Exports its Gray read pointer for synchronisation into the write domain.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/gray_ptr_cnt.sv | 40 ++++
 rtl/fifo_rd_ctrl.sv | 96 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width and Gray-code helpers shared by the async FIFO read and write controllers.
// Helpers work on a PTR_MAX-wide container; callers zero-extend their ADDR_W+1-bit pointers.
package fifo_pkg;

    localparam int MIN_DEPTH = 4;
    localparam int PTR_MAX   = 32;

    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < PTR_MAX; i++) b = b ^ (g >> i);
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_cnt.sv
// gray_ptr_cnt: enable-driven binary pointer with a registered Gray copy; shared by both FIFO sides.
module gray_ptr_cnt
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] bin,
    output logic [W-1:0] bin_next,
    output logic [W-1:0] gray,
    output logic [W-1:0] gray_next
);

    logic [W-1:0] bin_q, bin_d, gray_q, gray_d;
    ptr_t         g_full;

    always_comb begin
        bin_d  = bin_q + W'(en);
        g_full = bin2gray(ptr_t'(bin_d));
        gray_d = g_full[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin       = bin_q;
    assign bin_next  = bin_d;
    assign gray      = gray_q;
    assign gray_next = gray_d;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer/flag controller of the async AXIS FIFO with FWFT output.
// Define FIFO_RD_COUNT_EN to build the rd_count / almost_empty occupancy logic.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH = 16,
    parameter  int DATA_W     = 32,
    parameter  int AE_THRESH  = 2,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH),
    localparam int PW         = ptr_w(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW-1:0]     wr_ptr_gray_sync,
    output logic [PW-1:0]     rd_ptr_gray,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              empty,
    output logic              almost_empty,
    output logic [PW-1:0]     rd_count
);

    if (FIFO_DEPTH < MIN_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_rd_ctrl: FIFO_DEPTH must be a power of 2 and at least MIN_DEPTH");
    end

    logic [PW-1:0] rd_bin, rd_bin_next, rd_gray_next;
    logic          tvalid_q, tvalid_d, empty_q, empty_d;
    logic          unused_ok;

    gray_ptr_cnt #(.W(PW)) u_rd_ptr (
        .clk       (clk),
        .rst       (rst),
        .en        (mem_rd_en),
        .bin       (rd_bin),
        .bin_next  (rd_bin_next),
        .gray      (rd_ptr_gray),
        .gray_next (rd_gray_next)
    );

    // empty compares against the post-read pointer so a same-cycle read and sync update stay consistent
    always_comb begin
        mem_rd_en = !empty_q && (!tvalid_q || m_axis_tready);
        tvalid_d  = mem_rd_en || (tvalid_q && !m_axis_tready);
        empty_d   = rd_gray_next == wr_ptr_gray_sync;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            tvalid_q <= tvalid_d;
            empty_q  <= empty_d;
        end
    end

    assign mem_rd_addr   = rd_bin[ADDR_W-1:0];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = mem_rd_data;
    assign empty         = empty_q;
    assign unused_ok     = ^{rd_bin[PW-1:ADDR_W], rd_bin_next};

`ifdef FIFO_RD_COUNT_EN
    ptr_t          wr_bin_full;
    logic [PW-1:0] rd_count_q, rd_count_d;
    logic          ae_q, ae_d;

    always_comb begin
        wr_bin_full = gray2bin(ptr_t'(wr_ptr_gray_sync));
        rd_count_d  = wr_bin_full[PW-1:0] - rd_bin_next;
        ae_d        = rd_count_d <= PW'(AE_THRESH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            ae_q       <= 1'b1;
        end else begin
            rd_count_q <= rd_count_d;
            ae_q       <= ae_d;
        end
    end

    assign rd_count     = rd_count_q;
    assign almost_empty = ae_q;
`else
    assign rd_count     = '0;
    assign almost_empty = empty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scenario tasks plus a per-cycle FIFO-order scoreboard for fifo_rd_ctrl.
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PW    = 5;
    localparam int DW    = 32;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] wr_sync = '0;
    logic [PW-1:0] rd_gray, rd_count;
    logic          mem_rd_en, tvalid, empty, almost_empty;
    logic          tready = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] tdata;
    logic [DW-1:0] ram [DEPTH];

    int checks = 0;
    int errors = 0;
    int wr_n, iss_n, acc_n, cyc;
    logic [DW-1:0] q [$];
    logic          prev_hold;
    logic [DW-1:0] prev_data;
    logic [PW-1:0] prev_gray;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_W(DW), .AE_THRESH(AE)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_ptr_gray_sync (wr_sync),
        .rd_ptr_gray      (rd_gray),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (addr),
        .mem_rd_data      (rdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tready    (tready),
        .m_axis_tdata     (tdata),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .rd_count         (rd_count)
    );

    // registered-read RAM model
    always @(posedge clk) if (mem_rd_en) rdata <= ram[addr];

    function automatic logic [PW-1:0] g(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic clear_model();
        wr_n = 0; iss_n = 0; acc_n = 0; cyc = 0;
        q.delete();
        wr_sync = '0; tready = 1'b0;
        prev_hold = 1'b0; prev_gray = '0; prev_data = '0;
    endtask

    task automatic push();
        logic [DW-1:0] d;
        d = $urandom;
        ram[wr_n % DEPTH] = d;
        q.push_back(d);
        wr_n++;
        wr_sync = g(wr_n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one cycle: drive at negedge, publish up to npush words the RAM has room for, then score
    task automatic step(input logic rdy, input int npush);
        int w0;
        logic [DW-1:0] e;
`ifdef FIFO_RD_COUNT_EN
        logic [PW-1:0] ec;
`endif
        @(negedge clk);
        tready = rdy;
        w0 = wr_n;
        for (int k = 0; k < npush; k++) if (wr_n - iss_n < DEPTH) push();
        #1;
        checks++;
        if ($countones(rd_gray ^ prev_gray) > 1) begin
            errors++; $display("FAIL gray_step: got %b after %b, want at most one bit change", rd_gray, prev_gray);
        end
        checks++;
        if (!empty && iss_n >= w0) begin
            errors++; $display("FAIL false_nonempty: empty=%b with %0d unread, want 1", empty, w0 - iss_n);
        end
`ifdef FIFO_RD_COUNT_EN
        ec = PW'(w0 - iss_n);
        checks++;
        if (rd_count !== ec || almost_empty !== (ec <= PW'(AE))) begin
            errors++; $display("FAIL rd_count: got %0d ae=%b, want %0d ae=%b", rd_count, almost_empty, ec, ec <= PW'(AE));
        end
`else
        checks++;
        if (rd_count !== '0 || almost_empty !== empty) begin
            errors++; $display("FAIL count_off: got rd_count=%0d ae=%b, want 0 ae=%b", rd_count, almost_empty, empty);
        end
`endif
        if (prev_hold) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== prev_data) begin
                errors++; $display("FAIL hold_stable: got v=%b d=%h, want v=1 d=%h", tvalid, tdata, prev_data);
            end
        end
        if (tvalid && !tready) begin
            checks++;
            if (mem_rd_en !== 1'b0) begin
                errors++; $display("FAIL read_under_stall: got mem_rd_en=%b, want 0", mem_rd_en);
            end
        end
        if (mem_rd_en) begin
            checks++;
            if (iss_n >= w0 || addr !== AW'(iss_n % DEPTH)) begin
                errors++; $display("FAIL rd_addr: got %0d with %0d unread, want %0d", addr, w0 - iss_n, iss_n % DEPTH);
            end
            iss_n++;
        end
        if (tvalid && tready) begin
            checks++;
            if (q.size() == 0) begin
                errors++; $display("FAIL beat_extra: got beat %h, want none", tdata);
            end else begin
                e = q.pop_front();
                if (tdata !== e) begin
                    errors++; $display("FAIL beat_data: got %h, want %h", tdata, e);
                end
            end
            acc_n++;
        end
        prev_hold = tvalid && !tready;
        prev_data = tdata;
        prev_gray = rd_gray;
        cyc++;
    endtask

    task automatic test_reset();
        clear_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tvalid !== 1'b0 || rd_gray !== '0 || empty !== 1'b1 || rd_count !== '0 || almost_empty !== 1'b1) begin
            errors++; $display("FAIL reset_state: got v=%b g=%b e=%b c=%0d ae=%b, want 0 0 1 0 1", tvalid, rd_gray, empty, rd_count, almost_empty);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3);
        step(1'b0, 0);
        step(1'b0, 0);
        checks++;
        if (tvalid !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL pre_reset_stream: got v=%b e=%b, want v=1 e=0", tvalid, empty);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tvalid !== 1'b0 || rd_gray !== '0 || empty !== 1'b1 || rd_count !== '0) begin
            errors++; $display("FAIL async_reset: got v=%b g=%b e=%b c=%0d, want 0 0 1 0", tvalid, rd_gray, empty, rd_count);
        end
        clear_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [DW-1:0] d0;
        do_reset();
        step(1'b1, 1);
        d0 = ram[0];
        checks++;
        if (mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL single_early: got mem_rd_en=%b, want 0", mem_rd_en);
        end
        step(1'b1, 0);
        checks++;
        if (mem_rd_en !== 1'b1 || addr !== '0) begin
            errors++; $display("FAIL single_read: got en=%b addr=%0d, want en=1 addr=0", mem_rd_en, addr);
        end
        step(1'b1, 0);
        checks++;
        if (tvalid !== 1'b1 || tdata !== d0 || rd_gray !== 5'b00001 || empty !== 1'b1 || mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL single_beat: got v=%b d=%h g=%b e=%b en=%b, want 1 %h 00001 1 0", tvalid, tdata, rd_gray, empty, mem_rd_en, d0);
        end
        step(1'b1, 0);
        checks++;
        if (tvalid !== 1'b0) begin
            errors++; $display("FAIL single_done: got tvalid=%b, want 0", tvalid);
        end
    endtask

    task automatic test_back_to_back();
        int rc, c0, c1;
        do_reset();
        rc = 0; c0 = -1; c1 = 0;
        step(1'b1, 16);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 0);
            if (mem_rd_en) begin
                if (c0 < 0) c0 = i;
                c1 = i;
                rc++;
            end
        end
        checks++;
        if (rc != 16 || c1 - c0 != 15 || acc_n != 16) begin
            errors++; $display("FAIL b2b_reads: got %0d reads over %0d cycles, %0d beats, want 16 16 16", rc, c1 - c0 + 1, acc_n);
        end
        checks++;
        if (empty !== 1'b1 || rd_gray !== 5'b11000) begin
            errors++; $display("FAIL b2b_end: got e=%b g=%b, want e=1 g=11000", empty, rd_gray);
        end
    endtask

    task automatic test_backpressure();
        int rc, nb, c0, c1, a;
        do_reset();
        rc = 0; nb = 0; c0 = -1; c1 = 0;
        step(1'b0, 3);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0);
            if (mem_rd_en) rc++;
        end
        checks++;
        if (rc != 1 || tvalid !== 1'b1) begin
            errors++; $display("FAIL stall_reads: got %0d reads v=%b, want 1 read v=1", rc, tvalid);
        end
        for (int i = 0; i < 6; i++) begin
            a = acc_n;
            step(1'b1, 0);
            if (acc_n != a) begin
                if (c0 < 0) c0 = i;
                c1 = i;
                nb++;
            end
        end
        checks++;
        if (nb != 3 || c1 - c0 != 2) begin
            errors++; $display("FAIL stall_release: got %0d beats spanning %0d cycles, want 3 beats spanning 3", nb, c1 - c0 + 1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 60; i++) step(1'b1, (i < 40) ? 1 : 0);
        checks++;
        if (acc_n != 40 || rd_gray !== g(40) || empty !== 1'b1) begin
            errors++; $display("FAIL wrap: got %0d beats g=%b e=%b, want 40 g=%b e=1", acc_n, rd_gray, empty, g(40));
        end
    endtask

    task automatic test_count();
        int ex;
        do_reset();
        step(1'b1, 10);
        for (int k = 1; k <= 14; k++) begin
            step(1'b1, 0);
            ex = (k <= 11) ? 11 - k : 0;
`ifdef FIFO_RD_COUNT_EN
            checks++;
            if (rd_count !== PW'(ex) || almost_empty !== (ex <= AE)) begin
                errors++; $display("FAIL count_seq: step %0d got %0d ae=%b, want %0d ae=%b", k, rd_count, almost_empty, ex, ex <= AE);
            end
`else
            checks++;
            if (rd_count !== '0) begin
                errors++; $display("FAIL count_tied: step %0d got %0d, want 0", k, rd_count);
            end
`endif
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int i = 0; i < 800; i++) step(($urandom % 4) != 0, $urandom % 3);
        n = 0;
        while (acc_n < wr_n && n < 100) begin
            step(1'b1, 0);
            n++;
        end
        checks++;
        if (acc_n != wr_n || q.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d of %0d beats, %0d left, want all", acc_n, wr_n, q.size());
        end
        step(1'b1, 0);
        step(1'b1, 0);
        checks++;
        if (empty !== 1'b1 || rd_gray !== g(wr_n) || tvalid !== 1'b0) begin
            errors++; $display("FAIL random_end: got e=%b g=%b v=%b, want e=1 g=%b v=0", empty, rd_gray, tvalid, g(wr_n));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
